// File: rtl/sparce_sasa_table.sv
// sparce skip-address table: software-programmed PC -> (rs1, rs2, cond, skip)
// entries, with a fully associative lookup of the fetch PC and a 1-cycle latency.
module sparce_sasa_table #(
  parameter int          NENTRIES  = 8,
  parameter logic [31:0] SASA_BASE = 32'h9000_1000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  input  logic        sasa_wen,
  input  logic        clear,
  output logic        hit,
  output logic [31:0] hit_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [1:0]  cond,
  output logic [31:0] sparce_target,
  output logic [5:0]  nvalid
);

  localparam int IW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] HAVE_PC = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   ppc_q, ppc_d;
  logic [IW-1:0] victim_q;

  logic [NENTRIES-1:0] valid_q;
  logic [31:0] epc_q  [NENTRIES];
  logic [4:0]  ers1_q [NENTRIES];
  logic [4:0]  ers2_q [NENTRIES];
  logic [1:0]  econd_q[NENTRIES];
  logic [15:0] eskip_q[NENTRIES];

  logic        hit_q;
  logic [31:0] hpc_q, tgt_q;
  logic [4:0]  rs1_q, rs2_q;
  logic [1:0]  cond_q;

  logic        wr_base, wr_cfg, commit;
  logic [4:0]  c_rs1, c_rs2;
  logic [1:0]  c_cond;
  logic [15:0] c_skip;

  assign wr_base = sasa_wen && (sasa_addr == SASA_BASE);
  assign wr_cfg  = sasa_wen && (sasa_addr == SASA_BASE + 32'd4);
  assign c_rs1   = sasa_data[4:0];
  assign c_rs2   = sasa_data[9:5];
  assign c_cond  = sasa_data[11:10];
  assign c_skip  = sasa_data[31:16];
  assign commit  = wr_cfg && (state_q == HAVE_PC) && !clear
                   && (c_cond != 2'b11) && (c_skip != 16'd0);

  // Config write FSM: latch a trigger PC, then wait for its config word
  always_comb begin
    state_d = state_q;
    ppc_d   = ppc_q;
    if (clear) begin
      state_d = IDLE;
      ppc_d   = 32'd0;
    end else if (wr_base) begin
      state_d = HAVE_PC;
      ppc_d   = {sasa_data[31:2], 2'b00};
    end else if (wr_cfg) begin
      state_d = IDLE;
    end
  end

  // Commit slot: in-place match, else lowest free slot, else victim
  logic          m_hit, f_hit, adv_victim;
  logic [IW-1:0] m_idx, f_idx, widx;
  always_comb begin
    m_hit = 1'b0;
    m_idx = '0;
    f_hit = 1'b0;
    f_idx = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (valid_q[i] && epc_q[i] == ppc_q) begin
        m_hit = 1'b1;
        m_idx = IW'(i);
      end
    end
    for (int i = NENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        f_hit = 1'b1;
        f_idx = IW'(i);
      end
    end
    widx = m_hit ? m_idx : (f_hit ? f_idx : victim_q);
    adv_victim = commit && !m_hit && !f_hit;
  end

  // Lookup: at most one entry can match, so OR-reduce the masked fields
  logic        lk_hit;
  logic [4:0]  lk_rs1, lk_rs2;
  logic [1:0]  lk_cond;
  logic [15:0] lk_skip;
  logic [31:0] lk_tgt;
  always_comb begin
    lk_hit  = 1'b0;
    lk_rs1  = '0;
    lk_rs2  = '0;
    lk_cond = '0;
    lk_skip = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (valid_q[i] && epc_q[i] == pc) begin
        lk_hit  = 1'b1;
        lk_rs1  = lk_rs1 | ers1_q[i];
        lk_rs2  = lk_rs2 | ers2_q[i];
        lk_cond = lk_cond | econd_q[i];
        lk_skip = lk_skip | eskip_q[i];
      end
    end
    lk_tgt = pc + (({16'd0, lk_skip} + 32'd1) << 2);
  end

  // Valid-entry population count
  always_comb begin
    nvalid = '0;
    for (int i = 0; i < NENTRIES; i++)
      nvalid = nvalid + 6'(valid_q[i]);
  end

  // FSM, pending PC and round-robin victim pointer
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ppc_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      ppc_q   <= ppc_d;
      if (clear)
        victim_q <= '0;
      else if (adv_victim)
        victim_q <= (victim_q == IW'(NENTRIES - 1)) ? '0 : victim_q + 1'b1;
    end
  end

  // Table storage: clear empties it, commit writes one slot
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < NENTRIES; i++) begin
        epc_q[i]   <= '0;
        ers1_q[i]  <= '0;
        ers2_q[i]  <= '0;
        econd_q[i] <= '0;
        eskip_q[i] <= '0;
      end
    end else if (clear) begin
      valid_q <= '0;
    end else if (commit) begin
      valid_q[widx] <= 1'b1;
      epc_q[widx]   <= ppc_q;
      ers1_q[widx]  <= c_rs1;
      ers2_q[widx]  <= c_rs2;
      econd_q[widx] <= c_cond;
      eskip_q[widx] <= c_skip;
    end
  end

  // Registered lookup result; clear suppresses the hit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_q  <= 1'b0;
      hpc_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      cond_q <= '0;
      tgt_q  <= 32'd4;
    end else if (clear || !lk_hit) begin
      hit_q  <= 1'b0;
      hpc_q  <= pc;
      rs1_q  <= '0;
      rs2_q  <= '0;
      cond_q <= '0;
      tgt_q  <= pc + 32'd4;
    end else begin
      hit_q  <= 1'b1;
      hpc_q  <= pc;
      rs1_q  <= lk_rs1;
      rs2_q  <= lk_rs2;
      cond_q <= lk_cond;
      tgt_q  <= lk_tgt;
    end
  end

  assign hit           = hit_q;
  assign hit_pc        = hpc_q;
  assign rs1           = rs1_q;
  assign rs2           = rs2_q;
  assign cond          = cond_q;
  assign sparce_target = tgt_q;

endmodule

// File: tb/tb_sparce_sasa_table.sv
// Directed bench for sparce_sasa_table: expected lookup results are queued
// when a PC is driven and compared against the registered outputs a cycle later.
module tb_sparce_sasa_table;

  localparam logic [31:0] B  = 32'h9000_1000;
  localparam logic [31:0] B4 = 32'h9000_1004;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] pc = '0, sasa_addr = '0, sasa_data = '0;
  logic        sasa_wen = 1'b0, clear = 1'b0;
  logic        hit;
  logic [31:0] hit_pc, sparce_target;
  logic [4:0]  rs1, rs2;
  logic [1:0]  cond;
  logic [5:0]  nvalid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        h;
    logic [31:0] hpc;
    logic [31:0] tgt;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [1:0]  c;
  } exp_t;

  exp_t sb[$];

  sparce_sasa_table dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .sasa_addr(sasa_addr),
    .sasa_data(sasa_data), .sasa_wen(sasa_wen), .clear(clear),
    .hit(hit), .hit_pc(hit_pc), .rs1(rs1), .rs2(rs2), .cond(cond),
    .sparce_target(sparce_target), .nvalid(nvalid)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t mk(logic h, logic [31:0] p, logic [31:0] t,
                              logic [4:0] a, logic [4:0] b, logic [1:0] c);
    exp_t e;
    e.h = h; e.hpc = p; e.tgt = t; e.r1 = a; e.r2 = b; e.c = c;
    return e;
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      cmp({tag, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    cmp({tag, " hit"}, 32'(hit), 32'(e.h));
    cmp({tag, " hit_pc"}, hit_pc, e.hpc);
    cmp({tag, " target"}, sparce_target, e.tgt);
    cmp({tag, " rs1"}, 32'(rs1), 32'(e.r1));
    cmp({tag, " rs2"}, 32'(rs2), 32'(e.r2));
    cmp({tag, " cond"}, 32'(cond), 32'(e.c));
  endtask

  task automatic cyc(string tag, logic [31:0] p, logic w, logic [31:0] a,
                     logic [31:0] d, logic clr, logic chk, exp_t e);
    pc = p; sasa_wen = w; sasa_addr = a; sasa_data = d; clear = clr;
    if (chk) sb.push_back(e);
    @(posedge CLK);
    #1;
    sasa_wen = 1'b0; clear = 1'b0;
    if (chk) check_out(tag);
  endtask

  task automatic st(logic [31:0] a, logic [31:0] d);
    cyc("st", 32'h10, 1'b1, a, d, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic lk(string tag, logic [31:0] p, logic h, logic [4:0] a,
                    logic [4:0] b, logic [1:0] c, logic [31:0] t);
    cyc(tag, p, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, mk(h, p, t, a, b, c));
  endtask

  task automatic chkn(string tag, int n);
    cmp({tag, " nvalid"}, 32'(nvalid), 32'(n));
  endtask

  task automatic chk_reset(string tag);
    cmp({tag, " hit"}, 32'(hit), 32'd0);
    cmp({tag, " hit_pc"}, hit_pc, 32'd0);
    cmp({tag, " target"}, sparce_target, 32'd4);
    cmp({tag, " rs1"}, 32'(rs1), 32'd0);
    cmp({tag, " cond"}, 32'(cond), 32'd0);
    chkn(tag, 0);
  endtask

  initial begin
    @(posedge CLK);
    #1;
    chk_reset("reset");
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // basic entry
    st(B, 32'h100);
    st(B4, 32'h0003_0021);
    chkn("t1", 1);
    lk("t1 lk100", 32'h100, 1, 5'd1, 5'd1, 2'd0, 32'h110);

    // commit and lookup of the same new PC in one cycle
    st(B, 32'hC00);
    cyc("same", 32'hC00, 1'b1, B4, 32'h0001_0021, 1'b0, 1'b1,
        mk(0, 32'hC00, 32'hC04, 0, 0, 0));
    lk("same next", 32'hC00, 1, 5'd1, 5'd1, 2'd0, 32'hC08);
    chkn("same", 2);

    // lone config dropped, newest PC wins
    st(B4, 32'h0001_0402);
    chkn("t2 lone", 2);
    st(B, 32'h200);
    st(B, 32'h204);
    st(B4, 32'h0001_0402);
    chkn("t2", 3);
    lk("t2 lk200", 32'h200, 0, 5'd0, 5'd0, 2'd0, 32'h204);
    lk("t2 lk204", 32'h204, 1, 5'd2, 5'd0, 2'd1, 32'h20C);

    // in-place overwrite
    st(B, 32'h100);
    st(B4, 32'h0005_0021);
    chkn("t4", 3);
    lk("t4 lk100", 32'h100, 1, 5'd1, 5'd1, 2'd0, 32'h118);

    // reserved cond and zero skip are dropped
    st(B, 32'h300);
    st(B4, 32'h0002_0C21);
    chkn("t5 cond11", 3);
    st(B, 32'h300);
    st(B4, 32'h0000_0021);
    chkn("t5 skip0", 3);
    lk("t5 miss", 32'h300, 0, 5'd0, 5'd0, 2'd0, 32'h304);
    st(B, 32'h300);
    st(B4, 32'h0001_0021);
    chkn("t5 ok", 4);
    lk("t5 lk300", 32'h300, 1, 5'd1, 5'd1, 2'd0, 32'h308);

    // fill: PC low bits and config bits[15:12] ignored
    for (int k = 4; k < 8; k++) begin
      st(B, (32'(k) << 8) | 32'h3);
      st(B4, 32'h0001_F021);
    end
    chkn("t3 full", 8);
    lk("t3 lk400", 32'h400, 1, 5'd1, 5'd1, 2'd0, 32'h408);

    // replacement walks slots 0, 1, 2
    st(B, 32'h900);
    st(B4, 32'h0002_0021);
    chkn("t3 9th", 8);
    lk("t3 old0", 32'h100, 0, 5'd0, 5'd0, 2'd0, 32'h104);
    lk("t3 lk900", 32'h900, 1, 5'd1, 5'd1, 2'd0, 32'h90C);
    st(B, 32'hA00);
    st(B4, 32'h0001_0021);
    lk("t3 old1", 32'hC00, 0, 5'd0, 5'd0, 2'd0, 32'hC04);
    lk("t3 keep", 32'h204, 1, 5'd2, 5'd0, 2'd1, 32'h20C);
    st(B, 32'hFFFF_FFFC);
    st(B4, 32'h0001_0021);
    chkn("wrap", 8);
    lk("wrap old2", 32'h204, 0, 5'd0, 5'd0, 2'd0, 32'h208);
    lk("wrap tgt", 32'hFFFF_FFFC, 1, 5'd1, 5'd1, 2'd0, 32'h0000_0004);

    // clear with commit and lookup in the same cycle
    st(B, 32'h500);
    cyc("t6 clr", 32'h400, 1'b1, B4, 32'h0001_0021, 1'b1, 1'b1,
        mk(0, 32'h400, 32'h404, 0, 0, 0));
    chkn("t6 clr", 0);
    lk("t6 lk400", 32'h400, 0, 5'd0, 5'd0, 2'd0, 32'h404);
    lk("t6 lk500", 32'h500, 0, 5'd0, 5'd0, 2'd0, 32'h504);

    // reset pulse while a PC is pending
    st(B, 32'hB00);
    nRST = 1'b0;
    #2;
    chk_reset("t6 rst");
    nRST = 1'b1;
    st(B4, 32'h0001_0021);
    chkn("t6 drop", 0);
    lk("t6 lkB00", 32'hB00, 0, 5'd0, 5'd0, 2'd0, 32'hB04);

    cmp("sb drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
